// File: rtl/axi_mem_responder_if.sv
// ----------------------------------------------------------------------------
// axi_mem_responder_if
// Purpose : Bundles the five AXI4 channels of the 64-bit SweRVolf memory bus
//           so the block-RAM responder and its driver share one connection.
//           Signal names keep the responder's view (i_ = into the responder,
//           o_ = out of the responder) so they read the same on both sides.
// Modports: slave  - the responder (axi_mem_responder)
//           master - the bus driver (core interconnect or testbench)
// Channels: AW (id/addr/len/size/burst/valid/ready), W (data/strb/last/
//           valid/ready), B (id/resp/valid/ready), AR (as AW), R (id/data/
//           resp/last/valid/ready).
// ----------------------------------------------------------------------------
interface axi_mem_responder_if #(
  parameter int ID_WIDTH   = 6,
  parameter int ADDR_WIDTH = 27
) ();
  logic [ID_WIDTH-1:0]   i_awid;
  logic [ADDR_WIDTH-1:0] i_awaddr;
  logic [7:0]            i_awlen;
  logic [2:0]            i_awsize;
  logic [1:0]            i_awburst;
  logic                  i_awvalid;
  logic                  o_awready;

  logic [63:0]           i_wdata;
  logic [7:0]            i_wstrb;
  logic                  i_wlast;
  logic                  i_wvalid;
  logic                  o_wready;

  logic [ID_WIDTH-1:0]   o_bid;
  logic [1:0]            o_bresp;
  logic                  o_bvalid;
  logic                  i_bready;

  logic [ID_WIDTH-1:0]   i_arid;
  logic [ADDR_WIDTH-1:0] i_araddr;
  logic [7:0]            i_arlen;
  logic [2:0]            i_arsize;
  logic [1:0]            i_arburst;
  logic                  i_arvalid;
  logic                  o_arready;

  logic [ID_WIDTH-1:0]   o_rid;
  logic [63:0]           o_rdata;
  logic [1:0]            o_rresp;
  logic                  o_rlast;
  logic                  o_rvalid;
  logic                  i_rready;

  modport slave (
    input  i_awid, i_awaddr, i_awlen, i_awsize, i_awburst, i_awvalid,
    output o_awready,
    input  i_wdata, i_wstrb, i_wlast, i_wvalid,
    output o_wready,
    output o_bid, o_bresp, o_bvalid,
    input  i_bready,
    input  i_arid, i_araddr, i_arlen, i_arsize, i_arburst, i_arvalid,
    output o_arready,
    output o_rid, o_rdata, o_rresp, o_rlast, o_rvalid,
    input  i_rready
  );

  modport master (
    output i_awid, i_awaddr, i_awlen, i_awsize, i_awburst, i_awvalid,
    input  o_awready,
    output i_wdata, i_wstrb, i_wlast, i_wvalid,
    input  o_wready,
    input  o_bid, o_bresp, o_bvalid,
    output i_bready,
    output i_arid, i_araddr, i_arlen, i_arsize, i_arburst, i_arvalid,
    input  o_arready,
    input  o_rid, o_rdata, o_rresp, o_rlast, o_rvalid,
    output i_rready
  );
endinterface

// File: rtl/axi_mem_responder.sv
// ----------------------------------------------------------------------------
// axi_mem_responder
// Purpose : AXI4 slave backed by on-chip block RAM, standing in for the DDR2
//           controller on the SweRVolf 64-bit memory bus. It reproduces the
//           controller's init_done/init_error handshake so boot is unchanged.
// Ports   : clk          - clock
//           rst          - synchronous reset, active high
//           o_init_done  - memory ready, INIT_CYCLES cycles after reset
//           o_init_error - always 0
//           s_axi        - AXI4 AW/W/B/AR/R channels (slave modport)
// Notes   : Reads and writes are serialised through one FSM, so one set of
//           burst registers serves both directions and no hazard exists.
//           WRAP, reserved burst types and size > 3 answer SLVERR without
//           touching memory; beats at or beyond RAM_SIZE answer DECERR.
// ----------------------------------------------------------------------------
module axi_mem_responder #(
  parameter int          ID_WIDTH    = 6,
  parameter int          ADDR_WIDTH  = 27,
  parameter logic [31:0] RAM_SIZE    = 32'h10000,
  parameter int          INIT_CYCLES = 16,
  parameter string       MEM_FILE    = ""
) (
  input  logic               clk,
  input  logic               rst,
  output logic               o_init_done,
  output logic               o_init_error,
  axi_mem_responder_if.slave s_axi
);

  localparam int DEPTH = int'(RAM_SIZE / 8);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(INIT_CYCLES + 1);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_WDATA, S_WRESP, S_RDATA} state_t;

  state_t                r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_init_cnt;
  logic                  r_init_done;
  logic                  r_prio_wr;     // 1: write wins the next AW/AR tie

  logic [ID_WIDTH-1:0]   r_id;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [7:0]            r_len, r_beat;
  logic [2:0]            r_size;
  logic                  r_fixed, r_err;
  logic [1:0]            r_bresp, r_rresp, w_beat_resp;
  logic                  r_rvalid, r_rlast, r_rdone, r_rdata_ok;
  logic [63:0]           r_mem_q;
  logic [63:0]           r_mem [DEPTH];

  logic [IDX_W-1:0]      w_idx;
  logic                  w_in_range, w_last_beat;
  logic                  w_grant_wr, w_grant_rd;
  logic                  w_aw_hs, w_ar_hs, w_w_hs, w_r_hs, w_r_issue;
  logic                  w_unused;

  // Worst of two responses: DECERR > SLVERR > OKAY matches numeric order.
  function automatic logic [1:0] worst_resp(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Bursts this memory does not serve: WRAP, the reserved encoding, and
  // beats wider than the 64-bit bus.
  function automatic logic burst_err(input logic [1:0] burst, input logic [2:0] size);
    return ((burst != BURST_FIXED) && (burst != BURST_INCR)) || (size > 3'd3);
  endfunction

  // The beat count alone decides the end of a write burst.
  assign w_unused = s_axi.i_wlast;

  // Per-beat address decode shared by the write and read paths.
  assign w_idx       = r_addr[IDX_W+2:3];
  assign w_in_range  = ({{(64-ADDR_WIDTH){1'b0}}, r_addr} < {32'd0, RAM_SIZE});
  assign w_beat_resp = r_err ? RESP_SLVERR : (w_in_range ? RESP_OKAY : RESP_DECERR);
  assign w_last_beat = (r_beat == r_len);
  assign w_addr_nxt  = r_fixed ? r_addr : r_addr + (ADDR_WIDTH'(1) << r_size);

  assign w_aw_hs   = w_grant_wr && s_axi.i_awvalid;
  assign w_ar_hs   = w_grant_rd && s_axi.i_arvalid;
  assign w_w_hs    = (r_state == S_WDATA) && s_axi.i_wvalid;
  assign w_r_hs    = r_rvalid && s_axi.i_rready;
  // Fetch the next read beat whenever the output register is empty or drains.
  assign w_r_issue = (r_state == S_RDATA) && !r_rdone && (!r_rvalid || s_axi.i_rready);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_INIT;
    else     r_state <= w_state_nxt;
  end

  // FSM next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_INIT:  if (r_init_cnt == CNT_W'(INIT_CYCLES - 1)) w_state_nxt = S_IDLE;
      S_IDLE:  begin
        if (w_aw_hs)      w_state_nxt = S_WDATA;
        else if (w_ar_hs) w_state_nxt = S_RDATA;
      end
      S_WDATA: if (w_w_hs && w_last_beat) w_state_nxt = S_WRESP;
      S_WRESP: if (s_axi.i_bready) w_state_nxt = S_IDLE;
      S_RDATA: if (w_r_hs && r_rlast) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_INIT;
    endcase
  end

  // FSM outputs: address grant arbitration and channel readiness
  always_comb begin
    w_grant_wr = 1'b0;
    w_grant_rd = 1'b0;
    if (r_state == S_IDLE) begin
      if (s_axi.i_awvalid && s_axi.i_arvalid) begin
        if (r_prio_wr) w_grant_wr = 1'b1;
        else           w_grant_rd = 1'b1;
      end else if (s_axi.i_arvalid) begin
        w_grant_rd = 1'b1;
      end else if (s_axi.i_awvalid) begin
        w_grant_wr = 1'b1;
      end
    end
    s_axi.o_awready = w_grant_wr;
    s_axi.o_arready = w_grant_rd;
    s_axi.o_wready  = (r_state == S_WDATA);
    s_axi.o_bvalid  = (r_state == S_WRESP);
  end

  // Init sequencing and arbitration priority
  always_ff @(posedge clk) begin
    if (rst) begin
      r_init_cnt  <= '0;
      r_init_done <= 1'b0;
      r_prio_wr   <= 1'b0;
    end else begin
      if (r_state == S_INIT) begin
        if (r_init_cnt == CNT_W'(INIT_CYCLES - 1)) r_init_done <= 1'b1;
        else                                       r_init_cnt  <= r_init_cnt + 1'b1;
      end
      if (w_aw_hs)      r_prio_wr <= 1'b0;
      else if (w_ar_hs) r_prio_wr <= 1'b1;
    end
  end

  // Burst capture, beat sequencing and the registered read output stage
  always_ff @(posedge clk) begin
    if (rst) begin
      r_id       <= '0;
      r_bresp    <= RESP_OKAY;
      r_rresp    <= RESP_OKAY;
      r_rlast    <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rdone    <= 1'b0;
      r_rdata_ok <= 1'b0;
    end else begin
      if (w_aw_hs) begin
        r_id    <= s_axi.i_awid;
        r_addr  <= s_axi.i_awaddr;
        r_len   <= s_axi.i_awlen;
        r_size  <= s_axi.i_awsize;
        r_fixed <= (s_axi.i_awburst == BURST_FIXED);
        r_err   <= burst_err(s_axi.i_awburst, s_axi.i_awsize);
        r_beat  <= 8'd0;
        r_bresp <= RESP_OKAY;
      end else if (w_ar_hs) begin
        r_id    <= s_axi.i_arid;
        r_addr  <= s_axi.i_araddr;
        r_len   <= s_axi.i_arlen;
        r_size  <= s_axi.i_arsize;
        r_fixed <= (s_axi.i_arburst == BURST_FIXED);
        r_err   <= burst_err(s_axi.i_arburst, s_axi.i_arsize);
        r_beat  <= 8'd0;
        r_rdone <= 1'b0;
      end

      if (w_w_hs) begin
        r_bresp <= worst_resp(r_bresp, w_beat_resp);
        r_addr  <= w_addr_nxt;
        r_beat  <= r_beat + 8'd1;
      end

      if (w_r_issue) begin
        r_rvalid   <= 1'b1;
        r_rresp    <= w_beat_resp;
        r_rlast    <= w_last_beat;
        r_rdata_ok <= (w_beat_resp == RESP_OKAY);
        r_addr     <= w_addr_nxt;
        r_beat     <= r_beat + 8'd1;
        if (w_last_beat) r_rdone <= 1'b1;
      end else if (w_r_hs) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  // Block RAM: byte-enabled write port and registered read port
  always_ff @(posedge clk) begin
    if (w_w_hs && (w_beat_resp == RESP_OKAY)) begin
      for (int b = 0; b < 8; b++) begin
        if (s_axi.i_wstrb[b]) r_mem[w_idx][8*b +: 8] <= s_axi.i_wdata[8*b +: 8];
      end
    end
    if (w_r_issue) r_mem_q <= r_mem[w_idx];
  end

  assign o_init_done   = r_init_done;
  assign o_init_error  = 1'b0;
  assign s_axi.o_bid   = r_id;
  assign s_axi.o_bresp = r_bresp;
  assign s_axi.o_rid   = r_id;
  assign s_axi.o_rdata = r_rdata_ok ? r_mem_q : 64'd0;
  assign s_axi.o_rresp = r_rresp;
  assign s_axi.o_rlast = r_rlast;
  assign s_axi.o_rvalid = r_rvalid;

endmodule

// File: tb/tb_axi_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_axi_mem_responder
// Purpose : Directed bench for axi_mem_responder. Stimulus tasks drive the
//           master side of the interface and push hand-computed expected R
//           beats and B responses into queues; a monitor pops and compares on
//           every R/B handshake and checks R stability while stalled.
// ----------------------------------------------------------------------------
module tb_axi_mem_responder;
  localparam int ID_W    = 6;
  localparam int ADDR_W  = 27;
  localparam int INIT_C  = 16;
  localparam logic [31:0] RAM_SZ = 32'h10000;

  typedef struct packed {
    logic [63:0]     data;
    logic [1:0]      resp;
    logic            last;
    logic [ID_W-1:0] id;
  } rbeat_t;

  typedef struct packed {
    logic [1:0]      resp;
    logic [ID_W-1:0] id;
  } bexp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic init_done, init_error;

  rbeat_t rq[$];
  bexp_t  bq[$];
  logic [63:0] wbuf [16];
  int total = 0;
  int bad   = 0;

  axi_mem_responder_if #(.ID_WIDTH(ID_W), .ADDR_WIDTH(ADDR_W)) bus ();

  axi_mem_responder #(
    .ID_WIDTH(ID_W), .ADDR_WIDTH(ADDR_W), .RAM_SIZE(RAM_SZ),
    .INIT_CYCLES(INIT_C), .MEM_FILE("")
  ) dut (
    .clk(clk), .rst(rst), .o_init_done(init_done), .o_init_error(init_error),
    .s_axi(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_r(input logic [63:0] d, input logic [1:0] r, input logic l, input logic [ID_W-1:0] id);
    rbeat_t e;
    e.data = d; e.resp = r; e.last = l; e.id = id;
    rq.push_back(e);
  endtask

  task automatic push_b(input logic [1:0] r, input logic [ID_W-1:0] id);
    bexp_t e;
    e.resp = r; e.id = id;
    bq.push_back(e);
  endtask

  task automatic wait_drain(input int max_cycles);
    int n;
    n = 0;
    while (((rq.size() + bq.size()) != 0) && (n < max_cycles)) begin
      tick();
      n++;
    end
    check("queue_drained", 64'(rq.size() + bq.size()), 64'd0);
  endtask

  task automatic set_aw(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] a,
                        input logic [7:0] len, input logic [2:0] sz, input logic [1:0] bt);
    bus.i_awid = id; bus.i_awaddr = a; bus.i_awlen = len; bus.i_awsize = sz; bus.i_awburst = bt;
  endtask

  task automatic set_ar(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] a,
                        input logic [7:0] len, input logic [2:0] sz, input logic [1:0] bt);
    bus.i_arid = id; bus.i_araddr = a; bus.i_arlen = len; bus.i_arsize = sz; bus.i_arburst = bt;
  endtask

  task automatic aw_go();
    int n; logic hs;
    n = 0; hs = 1'b0;
    bus.i_awvalid = 1'b1;
    while (!hs && n < 50) begin
      @(negedge clk);
      hs = bus.o_awready;
      tick();
      n++;
    end
    bus.i_awvalid = 1'b0;
    check("aw_handshake", hs, 1);
  endtask

  task automatic ar_go();
    int n; logic hs;
    n = 0; hs = 1'b0;
    bus.i_arvalid = 1'b1;
    while (!hs && n < 50) begin
      @(negedge clk);
      hs = bus.o_arready;
      tick();
      n++;
    end
    bus.i_arvalid = 1'b0;
    check("ar_handshake", hs, 1);
  endtask

  task automatic w_send(input logic [63:0] d, input logic [7:0] strb, input logic last);
    int n; logic hs;
    n = 0; hs = 1'b0;
    bus.i_wdata = d; bus.i_wstrb = strb; bus.i_wlast = last; bus.i_wvalid = 1'b1;
    while (!hs && n < 50) begin
      @(negedge clk);
      hs = bus.o_wready;
      tick();
      n++;
    end
    bus.i_wvalid = 1'b0;
    bus.i_wlast  = 1'b0;
    check("w_handshake", hs, 1);
  endtask

  task automatic do_write(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] a, input logic [7:0] len,
                          input logic [2:0] sz, input logic [1:0] bt, input logic [7:0] strb,
                          input logic [1:0] exp_resp);
    push_b(exp_resp, id);
    set_aw(id, a, len, sz, bt);
    aw_go();
    for (int k = 0; k <= int'(len); k++) w_send(wbuf[k], strb, (k == int'(len)));
    wait_drain(50);
  endtask

  // Expected beats must already be queued. stall=1 randomises i_rready.
  task automatic do_read(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] a, input logic [7:0] len,
                         input logic [2:0] sz, input logic [1:0] bt, input logic stall);
    int n;
    set_ar(id, a, len, sz, bt);
    ar_go();
    if (!stall) begin
      @(negedge clk);
      check("r_latency_n1", bus.o_rvalid, 0);
      @(negedge clk);
      check("r_latency_n2", bus.o_rvalid, 1);
      wait_drain(100);
    end else begin
      n = 0;
      while ((rq.size() != 0) && (n < 400)) begin
        tick();
        bus.i_rready = 1'($urandom_range(0, 1));
        n++;
      end
      bus.i_rready = 1'b1;
      check("stall_read_drained", 64'(rq.size()), 64'd0);
    end
  endtask

  // Call right after an edge at which rst was sampled high.
  task automatic init_seq();
    int n; logic rdy_seen, done;
    n = 0; rdy_seen = 1'b0; done = 1'b0;
    bus.i_awvalid = 1'b1;
    bus.i_arvalid = 1'b1;
    rst = 1'b0;
    while (!done && n < 100) begin
      @(negedge clk);
      if (init_done) done = 1'b1;
      else begin
        if (bus.o_awready || bus.o_arready) rdy_seen = 1'b1;
        @(posedge clk);
        n++;
      end
    end
    bus.i_awvalid = 1'b0;
    bus.i_arvalid = 1'b0;
    check("init_done_rise", done, 1);
    check("init_latency", 64'(n), 64'(INIT_C));
    check("ready_during_init", rdy_seen, 0);
    tick();
  endtask

  // Monitor: compares every R and B handshake against the queues
  initial begin : monitor
    rbeat_t e;
    bexp_t  be;
    logic stall;
    logic [63:0] sd;
    logic [2:0]  srl;
    stall = 1'b0; sd = '0; srl = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          check("r_stall_valid", bus.o_rvalid, 1);
          check("r_stall_data", bus.o_rdata, sd);
          check("r_stall_resp_last", {bus.o_rresp, bus.o_rlast}, srl);
        end
        if (bus.o_rvalid && bus.i_rready) begin
          if (rq.size() == 0) check("r_unexpected_beat", 1, 0);
          else begin
            e = rq.pop_front();
            check("r_data", bus.o_rdata, e.data);
            check("r_resp", bus.o_rresp, e.resp);
            check("r_last", bus.o_rlast, e.last);
            check("r_id", bus.o_rid, e.id);
          end
        end
        if (bus.o_bvalid && bus.i_bready) begin
          if (bq.size() == 0) check("b_unexpected", 1, 0);
          else begin
            be = bq.pop_front();
            check("b_resp", bus.o_bresp, be.resp);
            check("b_id", bus.o_bid, be.id);
          end
        end
        stall = bus.o_rvalid && !bus.i_rready;
        sd    = bus.o_rdata;
        srl   = {bus.o_rresp, bus.o_rlast};
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    bus.i_awvalid = 0; bus.i_wvalid = 0; bus.i_arvalid = 0;
    bus.i_wdata = '0; bus.i_wstrb = '0; bus.i_wlast = 0;
    bus.i_bready = 1'b1; bus.i_rready = 1'b1;
    set_aw('0, '0, 8'd0, 3'd3, 2'b01);
    set_ar('0, '0, 8'd0, 3'd3, 2'b01);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_init_done", init_done, 0);
    check("rst_init_error", init_error, 0);
    check("rst_rvalid", bus.o_rvalid, 0);
    check("rst_bvalid", bus.o_bvalid, 0);
    check("rst_wready", bus.o_wready, 0);
    check("rst_rlast", bus.o_rlast, 0);
    check("rst_rdata", bus.o_rdata, 0);
    check("rst_bresp_bid", {bus.o_bresp, bus.o_bid}, 0);
    check("rst_rid", bus.o_rid, 0);
    tick();
    init_seq();

    // INCR 4-beat write then read back
    wbuf[0] = 64'h1111_1111_1111_1111; wbuf[1] = 64'h2222_2222_2222_2222;
    wbuf[2] = 64'h3333_3333_3333_3333; wbuf[3] = 64'h4444_4444_4444_4444;
    do_write(6'd5, 27'h100, 8'd3, 3'd3, 2'b01, 8'hFF, 2'b00);
    push_r(64'h1111_1111_1111_1111, 2'b00, 1'b0, 6'd9);
    push_r(64'h2222_2222_2222_2222, 2'b00, 1'b0, 6'd9);
    push_r(64'h3333_3333_3333_3333, 2'b00, 1'b0, 6'd9);
    push_r(64'h4444_4444_4444_4444, 2'b00, 1'b1, 6'd9);
    do_read(6'd9, 27'h100, 8'd3, 3'd3, 2'b01, 1'b0);

    // Byte strobes over an all-ones word
    wbuf[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    do_write(6'd1, 27'h200, 8'd0, 3'd3, 2'b01, 8'hFF, 2'b00);
    wbuf[0] = 64'h0000_0000_0000_AABB;
    do_write(6'd2, 27'h200, 8'd0, 3'd3, 2'b01, 8'h03, 2'b00);
    push_r(64'hFFFF_FFFF_FFFF_AABB, 2'b00, 1'b1, 6'd3);
    do_read(6'd3, 27'h200, 8'd0, 3'd3, 2'b01, 1'b0);

    // Top-of-memory burst: second beat lands at RAM_SIZE
    wbuf[0] = 64'hDEAD_BEEF_0000_0001; wbuf[1] = 64'hBAD0_BAD0_BAD0_BAD0;
    do_write(6'd6, 27'hFFF8, 8'd1, 3'd3, 2'b01, 8'hFF, 2'b11);
    push_r(64'hDEAD_BEEF_0000_0001, 2'b00, 1'b0, 6'd7);
    push_r(64'd0, 2'b11, 1'b1, 6'd7);
    do_read(6'd7, 27'hFFF8, 8'd1, 3'd3, 2'b01, 1'b0);

    // WRAP write rejected, memory unchanged; WRAP read returns SLVERR/0
    wbuf[0] = 64'h5555_5555_5555_5555; wbuf[1] = 64'h6666_6666_6666_6666;
    do_write(6'd8, 27'h100, 8'd1, 3'd3, 2'b10, 8'hFF, 2'b10);
    push_r(64'h1111_1111_1111_1111, 2'b00, 1'b0, 6'd10);
    push_r(64'h2222_2222_2222_2222, 2'b00, 1'b1, 6'd10);
    do_read(6'd10, 27'h100, 8'd1, 3'd3, 2'b01, 1'b0);
    push_r(64'd0, 2'b10, 1'b1, 6'd11);
    do_read(6'd11, 27'h100, 8'd0, 3'd3, 2'b10, 1'b0);

    // Size 2 INCR: 0x100 then 0x104, both inside the same 64-bit word
    push_r(64'h1111_1111_1111_1111, 2'b00, 1'b0, 6'd12);
    push_r(64'h1111_1111_1111_1111, 2'b00, 1'b1, 6'd12);
    do_read(6'd12, 27'h100, 8'd1, 3'd2, 2'b01, 1'b0);
    // FIXED: same word every beat
    push_r(64'h2222_2222_2222_2222, 2'b00, 1'b0, 6'd13);
    push_r(64'h2222_2222_2222_2222, 2'b00, 1'b0, 6'd13);
    push_r(64'h2222_2222_2222_2222, 2'b00, 1'b1, 6'd13);
    do_read(6'd13, 27'h108, 8'd2, 3'd3, 2'b00, 1'b0);
    // Size 4 is too wide for the bus
    push_r(64'd0, 2'b10, 1'b1, 6'd14);
    do_read(6'd14, 27'h100, 8'd0, 3'd4, 2'b01, 1'b0);

    // 8-beat burst, read back with random R stalls
    for (int k = 0; k < 8; k++) wbuf[k] = {32'hC0DE_0000 + 32'(k), 32'h5A5A_0000 + 32'(k)};
    do_write(6'd15, 27'h400, 8'd7, 3'd3, 2'b01, 8'hFF, 2'b00);
    for (int k = 0; k < 8; k++) push_r({32'hC0DE_0000 + 32'(k), 32'h5A5A_0000 + 32'(k)}, 2'b00, (k == 7), 6'd16);
    do_read(6'd16, 27'h400, 8'd7, 3'd3, 2'b01, 1'b1);

    // Reset in the middle of a read burst
    for (int k = 0; k < 8; k++) push_r({32'hC0DE_0000 + 32'(k), 32'h5A5A_0000 + 32'(k)}, 2'b00, (k == 7), 6'd17);
    set_ar(6'd17, 27'h400, 8'd7, 3'd3, 2'b01);
    ar_go();
    repeat (3) tick();
    rst = 1'b1;
    rq.delete();
    tick();
    check("midburst_rst_rvalid", bus.o_rvalid, 0);
    check("midburst_rst_init_done", init_done, 0);
    init_seq();

    // AW/AR contention: read wins first after reset, then write
    push_r(64'hFFFF_FFFF_FFFF_AABB, 2'b00, 1'b1, 6'd20);
    set_ar(6'd20, 27'h200, 8'd0, 3'd3, 2'b01);
    set_aw(6'd21, 27'h300, 8'd0, 3'd3, 2'b01);
    bus.i_arvalid = 1'b1; bus.i_awvalid = 1'b1;
    @(negedge clk);
    check("tie1_arready", bus.o_arready, 1);
    check("tie1_awready", bus.o_awready, 0);
    tick();
    bus.i_arvalid = 1'b0; bus.i_awvalid = 1'b0;
    wait_drain(50);
    push_b(2'b00, 6'd21);
    bus.i_arvalid = 1'b1; bus.i_awvalid = 1'b1;
    @(negedge clk);
    check("tie2_awready", bus.o_awready, 1);
    check("tie2_arready", bus.o_arready, 0);
    tick();
    bus.i_arvalid = 1'b0; bus.i_awvalid = 1'b0;
    w_send(64'h0123_4567_89AB_CDEF, 8'hFF, 1'b1);
    wait_drain(50);
    push_r(64'h0123_4567_89AB_CDEF, 2'b00, 1'b1, 6'd22);
    do_read(6'd22, 27'h300, 8'd0, 3'd3, 2'b01, 1'b0);

    repeat (5) tick();
    check("final_queues_empty", 64'(rq.size() + bq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
